// File: rtl/alu_input_sequencer_if.sv
// Pin-side bundle for the ALU input sequencer: switches and buttons in,
// ALU operands/opcode and LED status out.
interface alu_input_sequencer_if #(
    parameter int unsigned N_SW       = 16,
    parameter int unsigned N_OPERANDS = 8,
    parameter int unsigned N_OP       = 6
);
    logic [N_SW-1:0]       i_sw;
    logic                  i_button_A;
    logic                  i_button_B;
    logic                  i_button_Op;
    logic [N_OPERANDS-1:0] o_alu_A;
    logic [N_OPERANDS-1:0] o_alu_B;
    logic [N_OP-1:0]       o_alu_Op;
    logic                  o_valid;
    logic                  o_update;
    logic [1:0]            o_state;

    modport master (
        output i_sw, i_button_A, i_button_B, i_button_Op,
        input  o_alu_A, o_alu_B, o_alu_Op, o_valid, o_update, o_state
    );

    modport slave (
        input  i_sw, i_button_A, i_button_B, i_button_Op,
        output o_alu_A, o_alu_B, o_alu_Op, o_valid, o_update, o_state
    );
endinterface

// File: rtl/alu_input_sequencer.sv
// ALU front end: debounces three buttons and loads operand/opcode registers
// from the switches, either one button per register or via an enter sequence.
module alu_input_sequencer #(
    parameter int unsigned N_SW       = 16,
    parameter int unsigned N_OPERANDS = 8,
    parameter int unsigned N_OP       = 6,
    parameter int unsigned DB_CYCLES  = 4,
    parameter int unsigned SEQ_MODE   = 0
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    alu_input_sequencer_if.slave bus
);
    localparam int unsigned      CW      = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]    DB_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_A  = 2'b00,
        S_B  = 2'b01,
        S_OP = 2'b10
    } state_t;

    // Button index: 0 = A/enter, 1 = B/back, 2 = Op
    logic [2:0]            w_btn;
    logic [2:0]            r_sync1;
    logic [2:0]            r_sync2;
    logic [2:0]            r_stable;
    logic [2:0]            r_stable_d;
    logic [CW-1:0]         r_cnt [3];
    logic [2:0]            w_press;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            w_ld;
    logic                  w_valid_nxt;
    logic [2:0]            r_loaded;
    logic                  r_valid;
    logic                  r_update;
    logic [N_OPERANDS-1:0] r_alu_A;
    logic [N_OPERANDS-1:0] r_alu_B;
    logic [N_OP-1:0]       r_alu_Op;
    logic                  w_unused;

    assign w_btn    = {bus.i_button_Op, bus.i_button_B, bus.i_button_A};
    assign w_press  = r_stable & ~r_stable_d;
    assign w_unused = &{1'b0, bus.i_sw};

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
            for (int unsigned i = 0; i < 3; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1    <= w_btn;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            // Any cycle agreeing with the accepted level restarts the count
            for (int unsigned i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld        = '0;
        w_valid_nxt = r_valid;
        if (SEQ_MODE == 0) begin
            w_state_nxt = S_A;
            w_ld        = w_press;
            w_valid_nxt = &(r_loaded | w_press);
        end else if (w_press[1]) begin
            // Back has priority over a simultaneous enter
            w_state_nxt = S_A;
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                S_A: if (w_press[0]) begin
                    w_ld[0]     = 1'b1;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_B;
                end
                S_B: if (w_press[0]) begin
                    w_ld[1]     = 1'b1;
                    w_state_nxt = S_OP;
                end
                S_OP: if (w_press[0]) begin
                    w_ld[2]     = 1'b1;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_A;
                end
                default: w_state_nxt = S_A;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= S_A;
            r_loaded <= '0;
            r_valid  <= 1'b0;
            r_update <= 1'b0;
            r_alu_A  <= '0;
            r_alu_B  <= '0;
            r_alu_Op <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_loaded <= r_loaded | w_ld;
            r_valid  <= w_valid_nxt;
            r_update <= |w_ld;
            if (w_ld[0]) r_alu_A  <= bus.i_sw[N_OPERANDS-1:0];
            if (w_ld[1]) r_alu_B  <= bus.i_sw[N_OPERANDS-1:0];
            if (w_ld[2]) r_alu_Op <= bus.i_sw[N_OP-1:0];
        end
    end

    assign bus.o_alu_A  = r_alu_A;
    assign bus.o_alu_B  = r_alu_B;
    assign bus.o_alu_Op = r_alu_Op;
    assign bus.o_valid  = r_valid;
    assign bus.o_update = r_update;
    assign bus.o_state  = r_state;
endmodule
